seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Parametrised, time-multiplexed driver for a bank of seven-segment digits with decimal points. It latches a packed hex word on a load strobe and applies it only at frame boundaries, so the display never shows a mix of old and new digits. It scans the digits with a programmable prescaler and optionally blanks leading zeros. It sits between the datapath's display registers and the board's shared segment/anode pins, and supersedes the single-digit combinational hex decoder.

## Interface
- DIGITS, 4: number of digits scanned; must be ≥1.
- SCAN_DIV, 1000: clock cycles each digit is held; must be ≥1.
- ACTIVE_LOW, 1: 1 means seg and an are driven low for on; 0 means high for on.

- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  captures value/dp_in into the pending register.
- value  in  4*DIGITS  packed nibbles; nibble k ([4k+3:4k]) is digit k, digit 0 rightmost.
- dp_in  in  DIGITS  decimal point per digit, 1 means lit.
- blank_lz  in  1  enables leading-zero blanking.
- enable  in  1  0 means all digits dark (scan continues).
- seg  out  8  registered; seg[7]=dp, seg[6:0]=a..g (a at bit 6).
- an  out  DIGITS  registered one-hot digit select, polarity per ACTIVE_LOW.
- frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0.

## Operation
- Reset (asynchronous, immediate): prescaler=0, idx=0, pending=0, display=0, pend_valid=0, frame_tick=0, seg=all off, an=all off.
  - With ACTIVE_LOW=1: seg=8'hFF, an=all ones.
- Prescaler counts 0..SCAN_DIV-1. At terminal count (TC) it wraps to 0 and idx advances; DIGITS-1 wraps to 0.
- Load: any cycle with load=1 writes value/dp_in into pending and sets pend_valid. Back-to-back loads overwrite; the last one wins.
- Frame boundary (TC with idx=DIGITS-1):
  - display ← pending when pend_valid; pend_valid cleared.
  - If load=1 in that same cycle, the incoming value goes straight to display and pend_valid stays 0.
  - frame_tick=1 in the following cycle.
- Segment encoding: 0-9 and A-F with the standard a..g patterns; b and d are lowercase.
  - 0=1111110, 7=1110000, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Leading-zero blanking (blank_lz=1): digit k is blanked (segments off, dp still honoured) if its nibble and all higher nibbles are 0.
  - Digit 0 is never blanked, so value 0 shows "0".
  - blank_lz is sampled live.
- enable=0: an and seg are forced off. Prescaler, idx, load and frame_tick operate normally.

## Timing
- seg/an update in the cycle after the TC that selects the new idx. Each digit is held exactly SCAN_DIV cycles.
- A full frame is DIGITS*SCAN_DIV cycles; frame_tick period is identical.
- A load becomes visible at most one frame plus one cycle later, starting with digit 0.
- First frame after reset release shows display=0. an activates digit 0 one cycle after the first clock edge with reset low.
- SCAN_DIV=1: TC every cycle; digits rotate each cycle.
- DIGITS=1: every TC is a frame boundary.
- Reset asserted mid-frame: pending and display are discarded; no partial frame resumes.

## Structure
- Shared package seg7_pkg holds:
  - the 16-entry a..g pattern function seg7_hex;
  - SEG_BLANK (7'b0);
  - the polarity helper applying ACTIVE_LOW.
- One sub-module, seg7_hex_encode: combinational nibble + blank + dp to 8-bit active-high pattern. Polarity inversion is done in the top before the output register.
- Top holds prescaler, idx, pending/display registers, frame logic and output registers.

## Test plan
Common setup: DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1.
1. Reset, then load 16'h12AF, dp_in=0 → seg=8'hFF and an=4'hF before the first frame boundary. Next frame: digit 0 shows an=4'b1110, seg=8'hB8; digit 3 shows an=4'b0111, seg=8'hCF ("1").
2. Free run → an sequence 1110,1101,1011,0111, each held 4 cycles. frame_tick is one cycle high every 16 cycles.
3. blank_lz=1, load 16'h0070 → digits 3 and 2 show seg=8'hFF with an active; digit 1 shows 8'h8F; digit 0 shows 8'h81. With blank_lz=0, digits 3 and 2 show 8'h81.
4. Mid-frame load 16'h1111 then 16'h2222 → no change until the boundary; the next frame shows all "2". A load on the boundary cycle appears in that same frame.
5. dp_in=4'b0100 → seg[7]=0 only while an=4'b1011. enable=0 → an=4'hF, seg=8'hFF, frame_tick period unchanged.
6. Assert reset mid-digit with no clock edge → seg=8'hFF and an=4'hF immediately. After release, the scan restarts at digit 0 showing 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: hex glyph table,
// blank pattern and output polarity helper.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b000_0000;

  // a..g patterns, a at bit 6; b and d are lowercase glyphs.
  function automatic logic [6:0] seg7_hex(input logic [3:0] nibble);
    logic [6:0] pat;
    unique case (nibble)
      4'h0: pat = 7'b111_1110;
      4'h1: pat = 7'b011_0000;
      4'h2: pat = 7'b110_1101;
      4'h3: pat = 7'b111_1001;
      4'h4: pat = 7'b011_0011;
      4'h5: pat = 7'b101_1011;
      4'h6: pat = 7'b101_1111;
      4'h7: pat = 7'b111_0000;
      4'h8: pat = 7'b111_1111;
      4'h9: pat = 7'b111_1011;
      4'hA: pat = 7'b111_0111;
      4'hB: pat = 7'b001_1111;
      4'hC: pat = 7'b100_1110;
      4'hD: pat = 7'b011_1101;
      4'hE: pat = 7'b100_1111;
      4'hF: pat = 7'b100_0111;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  // Maps an active-high segment pattern onto the board's pin polarity.
  function automatic logic [7:0] seg7_polarity(input logic [7:0] pattern,
                                               input bit active_low);
    return active_low ? ~pattern : pattern;
  endfunction

endpackage

// File: rtl/seg7_hex_encode.sv
// Combinational glyph encoder: nibble, blank and decimal point to an
// active-high {dp, a..g} pattern.
module seg7_hex_encode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] pattern
);

  logic [6:0] glyph;

  always_comb begin
    glyph = seg7_hex(nibble);
    // Blanking removes only the glyph; the decimal point is still shown.
    if (blank) begin
      glyph = SEG_BLANK;
    end
    pattern = {dp, glyph};
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: prescaled digit scan, frame-aligned
// value updates, optional leading-zero blanking and registered pin outputs.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic                  enable,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF  = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{ACTIVE_LOW}};

  // Scan position
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tc;
  logic             boundary;

  // Pending (host-written) and display (frame-stable) copies
  logic [4*DIGITS-1:0] pend_q, pend_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_valid_q, pend_valid_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;

  // Output stage
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              frame_tick_q;

  logic [DIGITS-1:0] lz_mask;
  logic [3:0]        cur_nibble;
  logic              cur_dp;
  logic              cur_blank;
  logic [7:0]        seg_hi;
  logic [DIGITS-1:0] an_hi;

  assign tc       = (presc_q == CNT_LAST);
  assign boundary = tc && (idx_q == IDX_LAST);

  always_comb begin
    presc_d = presc_q + CNT_W'(1);
    idx_d   = idx_q;
    if (tc) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // A load on the boundary cycle bypasses pending so it shows in the frame
  // that is just starting.
  always_comb begin
    pend_d       = pend_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    disp_d       = disp_q;
    disp_dp_d    = disp_dp_q;
    if (load) begin
      pend_d       = value;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end
    if (boundary) begin
      pend_valid_d = 1'b0;
      if (load) begin
        disp_d    = value;
        disp_dp_d = dp_in;
      end else if (pend_valid_q) begin
        disp_d    = pend_q;
        disp_dp_d = pend_dp_q;
      end
    end
  end

  // lz_mask[k] is set when nibble k and every nibble above it are zero.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_mask  = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      all_zero   = all_zero && (disp_q[4*k +: 4] == 4'h0);
      lz_mask[k] = all_zero;
    end
  end

  always_comb begin
    cur_nibble = disp_q[{idx_q, 2'b00} +: 4];
    cur_dp     = disp_dp_q[idx_q];
    cur_blank  = blank_lz && lz_mask[idx_q];
  end

  seg7_hex_encode u_encode (
    .nibble  (cur_nibble),
    .blank   (cur_blank),
    .dp      (cur_dp),
    .pattern (seg_hi)
  );

  always_comb begin
    an_hi = DIGITS'(1) << idx_q;
    if (enable) begin
      seg_d = seg7_polarity(seg_hi, ACTIVE_LOW);
      an_d  = ACTIVE_LOW ? ~an_hi : an_hi;
    end else begin
      seg_d = SEG_OFF;
      an_d  = AN_OFF;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pend_q       <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      disp_q       <= '0;
      disp_dp_q    <= '0;
      frame_tick_q <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      frame_tick_q <= boundary;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, SCAN_DIV=4, active-low
// pins; expected glyph bytes are hand-computed.
module tb_seg7_scan_driver;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned SCAN_DIV = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic        enable;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  int total = 0;
  int bad   = 0;

  logic [7:0] cap_seg [4];
  logic [3:0] cap_an  [4];

  seg7_scan_driver #(
    .DIGITS     (DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .enable     (enable),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Called at a negedge; holds load for exactly one rising edge.
  task automatic drive_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    @(negedge clock);
    load  = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (frame_tick !== 1'b1 && n < 100);
    total++;
    if (frame_tick !== 1'b1) begin
      $display("FAIL wait_frame: got frame_tick=%b want 1 within 100 cycles", frame_tick);
      bad++;
    end
  endtask

  // Starts at the negedge where frame_tick is high; samples each digit's
  // first displayed cycle.
  task automatic capture_frame();
    for (int d = 0; d < 4; d++) begin
      @(negedge clock);
      cap_seg[d] = seg;
      cap_an[d]  = an;
      if (d < 3) repeat (3) @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0; enable = 1'b1;
    #1;
    total++; if (seg !== 8'hFF) begin $display("FAIL reset_seg: got %h want ff", seg); bad++; end
    total++; if (an !== 4'hF) begin $display("FAIL reset_an: got %h want f", an); bad++; end
    total++; if (frame_tick !== 1'b0) begin
      $display("FAIL reset_tick: got %b want 0", frame_tick); bad++;
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    total++; if (an !== 4'b1110) begin $display("FAIL first_an: got %b want 1110", an); bad++; end
    total++; if (seg !== 8'h81) begin $display("FAIL first_seg: got %h want 81", seg); bad++; end
  endtask

  task automatic test_first_load();
    logic [7:0] exp_seg [4];
    exp_seg = '{8'hB8, 8'h88, 8'h92, 8'hCF};
    drive_load(16'h12AF, 4'b0000);
    wait_frame();
    capture_frame();
    for (int d = 0; d < 4; d++) begin
      logic [3:0] exp_an;
      exp_an = ~(4'b0001 << d);
      total++; if (cap_an[d] !== exp_an) begin
        $display("FAIL load_an[%0d]: got %b want %b", d, cap_an[d], exp_an); bad++;
      end
      total++; if (cap_seg[d] !== exp_seg[d]) begin
        $display("FAIL load_seg[%0d]: got %h want %h", d, cap_seg[d], exp_seg[d]); bad++;
      end
    end
  endtask

  task automatic test_free_run();
    wait_frame();
    for (int j = 1; j <= 16; j++) begin
      logic [3:0] exp_an;
      logic       exp_tick;
      @(negedge clock);
      exp_an   = ~(4'b0001 << ((j - 1) / 4));
      exp_tick = (j == 16);
      total++; if (an !== exp_an) begin
        $display("FAIL scan_an cycle %0d: got %b want %b", j, an, exp_an); bad++;
      end
      total++; if (frame_tick !== exp_tick) begin
        $display("FAIL scan_tick cycle %0d: got %b want %b", j, frame_tick, exp_tick); bad++;
      end
    end
  endtask

  task automatic test_blank_lz();
    logic [7:0] exp_on  [4];
    logic [7:0] exp_off [4];
    exp_on  = '{8'h81, 8'h8F, 8'hFF, 8'hFF};
    exp_off = '{8'h81, 8'h8F, 8'h81, 8'h81};
    blank_lz = 1'b1;
    drive_load(16'h0070, 4'b0000);
    wait_frame();
    capture_frame();
    for (int d = 0; d < 4; d++) begin
      logic [3:0] exp_an;
      exp_an = ~(4'b0001 << d);
      total++; if (cap_an[d] !== exp_an) begin
        $display("FAIL lz_an[%0d]: got %b want %b", d, cap_an[d], exp_an); bad++;
      end
      total++; if (cap_seg[d] !== exp_on[d]) begin
        $display("FAIL lz_on_seg[%0d]: got %h want %h", d, cap_seg[d], exp_on[d]); bad++;
      end
    end
    blank_lz = 1'b0;
    wait_frame();
    capture_frame();
    for (int d = 0; d < 4; d++) begin
      total++; if (cap_seg[d] !== exp_off[d]) begin
        $display("FAIL lz_off_seg[%0d]: got %h want %h", d, cap_seg[d], exp_off[d]); bad++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_seg [4];
    logic       seen_new;
    int         n;
    exp_seg = '{8'hB1, 8'hA4, 8'h88, 8'h81};
    wait_frame();
    repeat (5) @(negedge clock);
    drive_load(16'h1111, 4'b0000);
    drive_load(16'h2222, 4'b0000);
    seen_new = 1'b0;
    n = 0;
    do begin
      if (seg === 8'hCF || seg === 8'h92) seen_new = 1'b1;
      @(negedge clock);
      n++;
    end while (frame_tick !== 1'b1 && n < 100);
    total++; if (seen_new !== 1'b0) begin
      $display("FAIL midframe_hold: got early update=%b want 0", seen_new); bad++;
    end
    total++; if (frame_tick !== 1'b1) begin
      $display("FAIL midframe_tick: got %b want 1", frame_tick); bad++;
    end
    capture_frame();
    for (int d = 0; d < 4; d++) begin
      total++; if (cap_seg[d] !== 8'h92) begin
        $display("FAIL last_wins_seg[%0d]: got %h want 92", d, cap_seg[d]); bad++;
      end
    end
    // Load held across the boundary edge itself.
    wait_frame();
    repeat (15) @(negedge clock);
    drive_load(16'h0A5C, 4'b0000);
    total++; if (frame_tick !== 1'b1) begin
      $display("FAIL boundary_tick: got %b want 1", frame_tick); bad++;
    end
    capture_frame();
    for (int d = 0; d < 4; d++) begin
      total++; if (cap_seg[d] !== exp_seg[d]) begin
        $display("FAIL boundary_seg[%0d]: got %h want %h", d, cap_seg[d], exp_seg[d]); bad++;
      end
    end
  endtask

  task automatic test_dp_enable();
    logic [7:0] exp_seg [4];
    exp_seg = '{8'hB1, 8'hA4, 8'h08, 8'h81};
    drive_load(16'h0A5C, 4'b0100);
    wait_frame();
    capture_frame();
    for (int d = 0; d < 4; d++) begin
      total++; if (cap_seg[d] !== exp_seg[d]) begin
        $display("FAIL dp_seg[%0d]: got %h want %h", d, cap_seg[d], exp_seg[d]); bad++;
      end
    end
    enable = 1'b0;
    wait_frame();
    for (int j = 1; j <= 16; j++) begin
      logic exp_tick;
      @(negedge clock);
      exp_tick = (j == 16);
      total++; if (an !== 4'hF || seg !== 8'hFF) begin
        $display("FAIL disable_out cycle %0d: got an=%h seg=%h want an=f seg=ff", j, an, seg);
        bad++;
      end
      total++; if (frame_tick !== exp_tick) begin
        $display("FAIL disable_tick cycle %0d: got %b want %b", j, frame_tick, exp_tick); bad++;
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_mid_reset();
    repeat (6) @(negedge clock);
    drive_load(16'h9999, 4'b1111);
    #2;
    reset = 1'b1;
    #1;
    total++; if (seg !== 8'hFF) begin $display("FAIL midreset_seg: got %h want ff", seg); bad++; end
    total++; if (an !== 4'hF) begin $display("FAIL midreset_an: got %h want f", an); bad++; end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    total++; if (an !== 4'b1110) begin
      $display("FAIL restart_an: got %b want 1110", an); bad++;
    end
    total++; if (seg !== 8'h81) begin
      $display("FAIL restart_seg: got %h want 81", seg); bad++;
    end
    wait_frame();
    capture_frame();
    for (int d = 0; d < 4; d++) begin
      total++; if (cap_seg[d] !== 8'h81) begin
        $display("FAIL discard_pending_seg[%0d]: got %h want 81", d, cap_seg[d]); bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_load();
    test_free_run();
    test_blank_lz();
    test_back_to_back();
    test_dp_enable();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
